drink_dispense_ctrl: RTL and testbench
======================================

Name: drink_dispense_ctrl

Overview:
- Parametrised successor to the 4:1 liquid-dispenser MUX.
- Generalised to N_CH channels of WIDTH-bit data.
- Adds a clocked pour controller: request/ready handshake, one-hot valve drive, pour-length countdown, empty-sensor interlock, and done/error reporting.
- Sits between the drink-order front end and the valve drivers. The registered output f carries the selected channel's data while a pour is active.

Parameters:
- N_CH, 4, number of beverage channels (2..16).
- WIDTH, 1, bits per channel data word and of f.
- LEN_W, 8, width of the pour-length field, in cycles.
- SEL_W, $clog2(N_CH) (min 1), width of the channel select (derived, not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pour request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_sel  in  SEL_W  requested channel index.
- req_len  in  LEN_W  pour duration in cycles.
- chan_data  in  N_CH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- chan_empty  in  N_CH  per-channel empty sensor, 1 = empty.
- valve  out  N_CH  one-hot valve enable; all zero when not pouring.
- f  out  WIDTH  registered selected-channel data; 0 when not pouring.
- busy  out  1  high in POUR or DONE.
- done  out  1  one-cycle pulse when a pour completes normally.
- err  out  1  one-cycle pulse on a rejected request or an aborted pour.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- All outputs are registered, except req_ready and busy, which decode the state register.
- Reset values:
  - State goes to IDLE.
  - valve=0, f=0, done=0, err=0, busy=0.
  - req_ready=1 once rst_n is high.
  - Internal sel_q=0, cnt=0.
- FSM states: IDLE, POUR, DONE.
- IDLE:
  - A request is accepted when req_valid && req_ready at a rising edge.
  - The request is rejected if req_sel >= N_CH, chan_empty[req_sel]=1, or req_len=0. On rejection: err=1 in the next cycle, state stays IDLE, no valve activity.
  - Otherwise: sel_q<=req_sel, cnt<=req_len, state goes to POUR.
- POUR:
  - valve = 1<<sel_q.
  - f holds chan_data[sel_q] as sampled at the previous edge (1-cycle latency). f loads whenever the next state is POUR, so it aligns with valve.
  - cnt decrements each cycle.
  - When cnt==1 at an edge, the next state is DONE.
  - Valve is high for exactly req_len cycles. For accept edge T0, valve is high during cycles T1..T_len.
- DONE:
  - Lasts one cycle: done=1, valve=0, f=0, busy=1, req_ready=0.
  - Then state goes to IDLE.
  - Minimum accept-to-accept spacing is req_len+2 cycles.
- Empty mid-pour:
  - Condition: chan_empty[sel_q]=1 sampled in POUR.
  - Next cycle: valve=0, f=0, err=1, done=0, state goes directly to IDLE (no DONE).
  - Abort takes priority over normal completion on the same edge.
- Changes to chan_empty on non-selected channels have no effect.
- req_sel and req_len are ignored while req_ready=0; there is no queueing.
- req_len = all-ones (255) is legal and pours 255 cycles. There is no wrap: cnt stops at 0.
- Reset mid-pour: valve, f, done and err drop immediately (asynchronous). The next request is accepted on the first edge after rst_n is released.

Optional Feature:
- Macro: DISP_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 sampled in POUR behaves exactly like the empty-abort: valve=0 and err=1 next cycle, then IDLE.
  - abort in IDLE or DONE is ignored.
  - If abort coincides with the final count, abort wins.
- When undefined:
  - The port does not exist and behaviour is as above.

Decomposition:
- Package drink_disp_pkg holds:
  - the state enum (IDLE, POUR, DONE);
  - a localparam function for SEL_W;
  - the ERR codes, used by the bench only.
- Sub-module chan_mux (parametrised N_CH, WIDTH): combinational N:1 word select. It is the generalised successor of the original MUX and is instantiated once for the f path.
- Counter and FSM stay in the top module.

Test Plan (N_CH=4, WIDTH=8, LEN_W=8):
- Reset and normal pour:
  - Stimulus: reset, then req sel=2, len=3, chan_data[2]=0xA5.
  - Response: valve=4'b0100 for exactly 3 cycles, f=0xA5 over the same cycles, done pulse one cycle later, req_ready back high the cycle after that.
- Exhaustive select (mirrors the original MUX check):
  - Stimulus: for each sel 0..3, len=1, chan_data={0x44,0x33,0x22,0x11}.
  - Response: f equals 0x11/0x22/0x33/0x44 respectively, and valve is one-hot matching sel.
- Rejections:
  - Stimulus: separately, len=0; chan_empty[1]=1 with sel=1; sel=5 at N_CH=5 (rebuild).
  - Response: err one cycle, valve never asserted, state stays IDLE.
- Empty mid-pour:
  - Stimulus: sel=0, len=10; raise chan_empty[0] on the 4th pour cycle.
  - Response: valve drops next cycle, err=1, done never pulses. Raising chan_empty[3] instead has no effect.
- Back-pressure and async reset:
  - Stimulus: hold req_valid during a pour with a changing sel; separately, assert rst_n=0 mid-pour, off-edge.
  - Response: the held request is accepted only after DONE, using the values present at that edge. On reset, valve/f clear without waiting for a clock edge.
- DISP_ABORT_EN build:
  - Stimulus: abort on the same cycle as cnt==1.
  - Response: err=1, done=0, 0 extra valve cycles.

Source files
------------

// File: rtl/drink_disp_pkg.sv
// drink_disp_pkg: shared types for the drink dispense controller.
// Pour FSM states, select-width helper and error codes (bench only).
package drink_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POUR = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_REJECT = 2'd1;
   localparam logic [1:0] ERR_ABORT  = 2'd2;

   // Channel-select width, never below one bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chan_mux.sv
// chan_mux: combinational N_CH:1 word select.
// Ports: data (packed channels), sel (index), y (word, 0 if out of range).
module chan_mux #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1,
   parameter int SEL_W = 2
) (
   input  logic [N_CH*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == i[SEL_W-1:0]) begin
            y = data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/drink_dispense_ctrl.sv
// drink_dispense_ctrl: N-channel pour controller with valve drive,
// length countdown, empty interlock and done/err pulses.
// Ports: clk, rst_n, req_valid/req_ready/req_sel/req_len request,
// chan_data, chan_empty, valve (one-hot), f, busy, done, err.
// Optional: DISP_ABORT_EN adds input abort (cancel in POUR).
module drink_dispense_ctrl
   import drink_disp_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1,
   parameter int LEN_W = 8,
   localparam int SEL_W = sel_w(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef DISP_ABORT_EN
   input  logic                  abort,
`endif
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [SEL_W-1:0]      req_sel,
   input  logic [LEN_W-1:0]      req_len,
   input  logic [N_CH*WIDTH-1:0] chan_data,
   input  logic [N_CH-1:0]       chan_empty,
   output logic [N_CH-1:0]       valve,
   output logic [WIDTH-1:0]      f,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [N_CH-1:0] ONE = N_CH'(1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d, mux_sel;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [N_CH-1:0]   valve_d;
   logic [WIDTH-1:0]  f_d, mux_y;
   logic              done_d, err_d;
   logic              req_empty, stop;

   // In IDLE the mux looks at the incoming request so f is
   // already valid in the first valve cycle.
   assign mux_sel = (state_q == IDLE) ? req_sel : sel_q;

   chan_mux #(
      .N_CH  (N_CH),
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_mux (
      .data (chan_data),
      .sel  (mux_sel),
      .y    (mux_y)
   );

   // Out-of-range selects read as empty, folding both rejects.
   always_comb begin
      req_empty = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         if (req_sel == i[SEL_W-1:0]) begin
            req_empty = chan_empty[i];
         end
      end
   end

`ifdef DISP_ABORT_EN
   assign stop = chan_empty[sel_q] | abort;
`else
   assign stop = chan_empty[sel_q];
`endif

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q == POUR) || (state_q == DONE);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      valve_d = '0;
      f_d     = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_empty || req_len == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = POUR;
                  sel_d   = req_sel;
                  cnt_d   = req_len;
                  valve_d = ONE << req_sel;
                  f_d     = mux_y;
               end
            end
         end
         POUR: begin
            // Abort outranks the final count.
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q == LEN_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q - LEN_W'(1);
               valve_d = ONE << sel_q;
               f_d     = mux_y;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         valve   <= '0;
         f       <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         valve   <= valve_d;
         f       <= f_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// tb_drink_dispense_ctrl: directed bench for drink_dispense_ctrl
// (N_CH=4 and N_CH=5 instances, WIDTH=8, LEN_W=8).
module tb_drink_dispense_ctrl;
   import drink_disp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        abort;
   logic        req_valid, req_ready;
   logic [1:0]  req_sel;
   logic [7:0]  req_len;
   logic [31:0] chan_data;
   logic [3:0]  chan_empty;
   logic [3:0]  valve;
   logic [7:0]  f;
   logic        busy, done, err;

   logic        req_valid5, req_ready5;
   logic [2:0]  req_sel5;
   logic [7:0]  req_len5;
   logic [39:0] chan_data5;
   logic [4:0]  chan_empty5;
   logic [4:0]  valve5;
   logic [7:0]  f5;
   logic        busy5, done5, err5;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_f [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   always #5 clk = ~clk;

   drink_dispense_ctrl #(.N_CH(4), .WIDTH(8), .LEN_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DISP_ABORT_EN
      .abort      (abort),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sel    (req_sel),
      .req_len    (req_len),
      .chan_data  (chan_data),
      .chan_empty (chan_empty),
      .valve      (valve),
      .f          (f),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   drink_dispense_ctrl #(.N_CH(5), .WIDTH(8), .LEN_W(8)) dut5 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DISP_ABORT_EN
      .abort      (1'b0),
`endif
      .req_valid  (req_valid5),
      .req_ready  (req_ready5),
      .req_sel    (req_sel5),
      .req_len    (req_len5),
      .chan_data  (chan_data5),
      .chan_empty (chan_empty5),
      .valve      (valve5),
      .f          (f5),
      .busy       (busy5),
      .done       (done5),
      .err        (err5)
   );

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if (valve !== 4'b0 || f !== 8'h0 || done !== 1'b0 ||
          err !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_outs valve=%b f=%h done=%b err=%b busy=%b",
                  valve, f, done, err, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || req_ready5 !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready got %b/%b want 1", req_ready, req_ready5);
      end
   endtask

   task automatic test_normal();
      chan_data  = 32'h00A5_0000;
      chan_empty = 4'b0;
      req_sel    = 2'd2;
      req_len    = 8'd3;
      req_valid  = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (valve !== ((k <= 3) ? 4'b0100 : 4'b0000) ||
             f !== ((k <= 3) ? 8'hA5 : 8'h00) ||
             done !== (k == 4) || req_ready !== (k == 5) ||
             busy !== (k <= 4) || err !== 1'b0) begin
            fails++;
            $display("FAIL normal k=%0d valve=%b f=%h done=%b rdy=%b busy=%b err=%b",
                     k, valve, f, done, req_ready, busy, err);
         end
      end
   endtask

   task automatic test_select();
      chan_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int s = 0; s < 4; s++) begin
         req_sel   = 2'(s);
         req_len   = 8'd1;
         req_valid = 1'b1;
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (valve !== 4'(1 << s) || f !== exp_f[s]) begin
            fails++;
            $display("FAIL select s=%0d valve=%b f=%h want %b/%h",
                     s, valve, f, 4'(1 << s), exp_f[s]);
         end
         @(negedge clk);
         tests++;
         if (done !== 1'b1 || valve !== 4'b0 || f !== 8'h0) begin
            fails++;
            $display("FAIL select_done s=%0d done=%b valve=%b f=%h",
                     s, done, valve, f);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reject();
      for (int c = 0; c < 2; c++) begin
         chan_empty = (c == 1) ? 4'b0010 : 4'b0000;
         req_sel    = (c == 1) ? 2'd1 : 2'd0;
         req_len    = (c == 1) ? 8'd4 : 8'd0;
         req_valid  = 1'b1;
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (err !== 1'b1 || valve !== 4'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reject c=%0d kind=%0d err=%b valve=%b rdy=%b",
                     c, ERR_REJECT, err, valve, req_ready);
         end
         @(negedge clk);
         tests++;
         if (err !== 1'b0 || valve !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reject_after c=%0d err=%b valve=%b busy=%b",
                     c, err, valve, busy);
         end
      end
      chan_empty = 4'b0;
      chan_data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      req_sel5   = 3'd5;
      req_len5   = 8'd3;
      req_valid5 = 1'b1;
      @(negedge clk);
      req_valid5 = 1'b0;
      tests++;
      if (err5 !== 1'b1 || valve5 !== 5'b0 || req_ready5 !== 1'b1) begin
         fails++;
         $display("FAIL reject_sel5 err=%b valve=%b rdy=%b",
                  err5, valve5, req_ready5);
      end
      @(negedge clk);
      req_sel5   = 3'd4;
      req_len5   = 8'd1;
      req_valid5 = 1'b1;
      @(negedge clk);
      req_valid5 = 1'b0;
      tests++;
      if (valve5 !== 5'b10000 || f5 !== 8'h55 || err5 !== 1'b0) begin
         fails++;
         $display("FAIL sel4_n5 valve=%b f=%h err=%b want 10000/55/0",
                  valve5, f5, err5);
      end
      @(negedge clk);
      tests++;
      if (done5 !== 1'b1 || valve5 !== 5'b0) begin
         fails++;
         $display("FAIL sel4_n5_done done=%b valve=%b", done5, valve5);
      end
      @(negedge clk);
   endtask

   task automatic test_empty_mid();
      req_sel   = 2'd0;
      req_len   = 8'd10;
      req_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (valve !== ((k <= 4) ? 4'b0001 : 4'b0000) ||
             err !== (k == 5) || done !== 1'b0 ||
             req_ready !== (k >= 5)) begin
            fails++;
            $display("FAIL empty_mid k=%0d kind=%0d valve=%b err=%b done=%b rdy=%b",
                     k, ERR_ABORT, valve, err, done, req_ready);
         end
         if (k == 4) chan_empty = 4'b0001;
      end
      chan_empty = 4'b0;
      req_len    = 8'd5;
      req_valid  = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         tests++;
         if (valve !== ((k <= 5) ? 4'b0001 : 4'b0000) ||
             err !== 1'b0 || done !== (k == 6) ||
             req_ready !== (k == 7)) begin
            fails++;
            $display("FAIL empty_other k=%0d valve=%b err=%b done=%b rdy=%b",
                     k, valve, err, done, req_ready);
         end
         if (k == 2) chan_empty = 4'b1000;
      end
      chan_empty = 4'b0;
   endtask

   task automatic test_back_to_back();
      chan_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req_sel   = 2'd1;
      req_len   = 8'd2;
      req_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         tests++;
         if (valve !== ((k <= 2) ? 4'b0010 :
                        (k == 5) ? 4'b1000 : 4'b0000) ||
             f !== ((k <= 2) ? 8'h22 : (k == 5) ? 8'h44 : 8'h00) ||
             done !== (k == 3 || k == 6) ||
             req_ready !== (k == 4)) begin
            fails++;
            $display("FAIL b2b k=%0d valve=%b f=%h done=%b rdy=%b",
                     k, valve, f, done, req_ready);
         end
         if (k == 1) req_sel = 2'd0;
         if (k == 2) begin
            req_sel = 2'd2;
            req_len = 8'd7;
         end
         if (k == 3) begin
            req_sel = 2'd3;
            req_len = 8'd1;
         end
         if (k == 5) req_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      chan_data = 32'h00A5_0000;
      req_sel   = 2'd2;
      req_len   = 8'd8;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (valve !== 4'b0100 || f !== 8'hA5) begin
         fails++;
         $display("FAIL areset_pre valve=%b f=%h", valve, f);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (valve !== 4'b0 || f !== 8'h0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL areset_now valve=%b f=%h busy=%b done=%b",
                  valve, f, busy, done);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      chan_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req_sel   = 2'd1;
      req_len   = 8'd1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      tests++;
      if (valve !== 4'b0010 || f !== 8'h22) begin
         fails++;
         $display("FAIL areset_after valve=%b f=%h want 0010/22", valve, f);
      end
      repeat (2) @(negedge clk);
   endtask

`ifdef DISP_ABORT_EN
   task automatic test_abort();
      req_sel   = 2'd0;
      req_len   = 8'd2;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (err !== 1'b1 || done !== 1'b0 || valve !== 4'b0) begin
         fails++;
         $display("FAIL abort_last err=%b done=%b valve=%b", err, done, valve);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_after done=%b err=%b rdy=%b", done, err, req_ready);
      end
   endtask
`endif

   initial begin
      rst_n       = 1'b0;
      abort       = 1'b0;
      req_valid   = 1'b0;
      req_sel     = '0;
      req_len     = '0;
      chan_data   = '0;
      chan_empty  = '0;
      req_valid5  = 1'b0;
      req_sel5    = '0;
      req_len5    = '0;
      chan_data5  = '0;
      chan_empty5 = '0;
      test_reset();
      test_normal();
      test_select();
      test_reject();
      test_empty_mid();
      test_back_to_back();
      test_async_reset();
`ifdef DISP_ABORT_EN
      test_abort();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
